mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised round-robin memory arbiter that merges NREQ independent requester ports (instruction/data ports of one or more datapaths) onto a single memory port. It replaces the fixed two-way instruction/data steering used today, adds fair rotation between requesters, abort on request withdrawal, and a wait-timeout watchdog. It sits between the datapath/cache request side and the RAM controller.

## Interface
- NREQ, 2, number of requester ports (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 0, max consecutive mem_wait cycles in one access before abort; 0 disables the watchdog
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- req_ren  in  NREQ  per-requester read request
- req_wen  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  per-requester address, requester i at bits [i*AW +: AW]
- req_store  in  NREQ*DW  per-requester write data, same packing
- req_hit  out  NREQ  one-cycle completion pulse to the granted requester
- req_load  out  DW  read data, valid when the matching req_hit bit is high
- mem_ren  out  1  memory read strobe
- mem_wen  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_store  out  DW  memory write data
- mem_load  in  DW  memory read data
- mem_wait  in  1  memory busy; access completes in the first ACCESS cycle with mem_wait low
- grant_valid  out  1  high while in ACCESS
- grant_id  out  clog2(NREQ)  index of the granted requester
- err_timeout  out  1  one-cycle pulse when the watchdog aborts an access

## Operation
- States: IDLE, ACCESS. Reset enters IDLE.
- Requester i is requesting when req_ren[i] | req_wen[i].
- IDLE: if any requester is requesting, select the first requesting index found scanning ptr, ptr+1, ..., wrapping mod NREQ. Register grant_id, latch that requester's addr/store into mem_addr/mem_store, go to ACCESS. No request: stay in IDLE.
- ACCESS: mem_wen = req_wen[g]; mem_ren = req_ren[g] & ~req_wen[g] (write wins when both set). Address/data come from the latched copies and do not follow requester changes.
- Completion: ACCESS, request still present, mem_wait low -> req_hit[g]=1 that cycle, req_load = mem_load (combinational pass-through), next state IDLE.
- Abort: ACCESS and requester g drops both ren and wen -> mem strobes low that cycle, no hit, next state IDLE.
- Watchdog: wait counter clears on entry to ACCESS and increments each ACCESS cycle with mem_wait high. When TIMEOUT != 0 and the counter reaches TIMEOUT, pulse err_timeout in the following cycle, drive mem strobes low, assert no hit, return to IDLE. Counter width is clog2(TIMEOUT+1); it saturates, never wraps.
- Rotation: on every exit from ACCESS (completion, abort, timeout), ptr = (g+1) mod NREQ. Exit from ACCESS always passes through one IDLE cycle, so a requester holding its request after a hit is re-arbitrated fairly.
- req_hit bits other than g are always 0; at most one req_hit bit is high in any cycle.

## Timing
- Reset values: state IDLE, ptr 0, grant_id 0, grant_valid 0, mem_ren 0, mem_wen 0, mem_addr 0, mem_store 0, req_hit 0, err_timeout 0, wait counter 0. req_load is don't-care during reset.
- Minimum latency: request sampled in IDLE at cycle 0, ACCESS with strobes in cycle 1, hit in cycle 1 if mem_wait low. Back-to-back accesses complete every 2 cycles at best.
- With mem_wait high for W cycles, hit occurs W+1 cycles after entry to ACCESS.
- In IDLE, mem_ren/mem_wen are 0; mem_addr/mem_store hold their last latched values.
- Asynchronous reset mid-ACCESS: strobes drop immediately, no hit, ptr returns to 0.
- Simultaneous completion and withdrawal in the same cycle cannot occur: withdrawal takes precedence (no hit).

## Test plan
- NREQ=2, req 0 read addr 0x100, mem_wait high 3 cycles then low, mem_load 0xDEADBEEF -> mem_ren high 4 cycles, req_hit=2'b01 and req_load=0xDEADBEEF in the 4th ACCESS cycle, then one IDLE cycle.
- NREQ=4, all four hold reads, mem_wait low -> grant_id sequence 0,1,2,3,0 with one hit every 2 cycles.
- Req 1 asserts ren and wen with store 0x12345678 -> mem_wen=1, mem_ren=0, mem_store=0x12345678.
- Req 0 granted, drops ren while mem_wait high -> no hit, back to IDLE, next grant goes to req 1 if requesting.
- TIMEOUT=4, mem_wait stuck high -> err_timeout pulses once, no hit, state IDLE, ptr advanced.
- Assert nRST low during ACCESS -> all outputs at reset values in the same cycle; after release, first grant goes to req 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging NREQ requester ports onto one memory port,
// with abort on request withdrawal and an optional mem_wait watchdog.
module mem_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 0,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_store,
  output logic [NREQ-1:0]    req_hit,
  output logic [DW-1:0]      req_load,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_store,
  input  logic [DW-1:0]      mem_load,
  input  logic               mem_wait,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic               err_timeout
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  grant_id_q;
  logic [IDW-1:0]  ptr_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_store_q;
  logic [CW-1:0]   wcnt_q;

  logic [NREQ-1:0] active_s;
  logic [IDW-1:0]  pick_s;
  logic [IDW-1:0]  next_ptr_s;
  logic            present_s;
  logic            timeout_s;

  // First requesting index found scanning ptr, ptr+1, ... modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] act,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && act[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
    return sel;
  endfunction

  assign active_s   = req_ren | req_wen;
  assign pick_s     = rr_pick(active_s, ptr_q);
  assign present_s  = active_s[grant_id_q];
  assign next_ptr_s = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
  assign timeout_s  = (TIMEOUT != 0) && (state_q == ACCESS) && (wcnt_q == CW'(TIMEOUT));

  // Memory strobes and completion follow the live request of the granted port.
  always_comb begin
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    req_hit     = '0;
    err_timeout = 1'b0;
    if (state_q == ACCESS) begin
      if (timeout_s) begin
        err_timeout = 1'b1;
      end else begin
        mem_wen = req_wen[grant_id_q];
        mem_ren = req_ren[grant_id_q] & ~req_wen[grant_id_q];
        if (present_s && !mem_wait) begin
          req_hit[grant_id_q] = 1'b1;
        end else begin
          req_hit = '0;
        end
      end
    end else begin
      err_timeout = 1'b0;
    end
  end

  // Arbitration FSM; every exit from ACCESS rotates the pointer past the grantee.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      ptr_q       <= '0;
      mem_addr_q  <= '0;
      mem_store_q <= '0;
      wcnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|active_s) begin
            state_q     <= ACCESS;
            grant_id_q  <= pick_s;
            mem_addr_q  <= req_addr[int'(pick_s)*AW +: AW];
            mem_store_q <= req_store[int'(pick_s)*DW +: DW];
            wcnt_q      <= '0;
          end
        end
        ACCESS: begin
          if (timeout_s || !present_s || !mem_wait) begin
            state_q <= IDLE;
            ptr_q   <= next_ptr_s;
            wcnt_q  <= '0;
          end else if (wcnt_q != {CW{1'b1}}) begin
            wcnt_q <= wcnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_valid = (state_q == ACCESS);
  assign grant_id    = grant_id_q;
  assign mem_addr    = mem_addr_q;
  assign mem_store   = mem_store_q;
  assign req_load    = mem_load;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, corner sequences, and random traffic
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [N-1:0]  ren, wen, req_hit;
  logic [N*32-1:0] req_addr, req_store;
  logic [31:0]   req_load, mem_addr, mem_store, mem_load;
  logic          mem_ren, mem_wen, mem_wait, grant_valid, err_timeout;
  logic [1:0]    grant_id;
  logic [31:0]   a_arr[N];
  logic [31:0]   s_arr[N];

  int passed = 0;
  int total  = 0;

  bit          m_busy;
  int          m_g, m_ptr, m_waits;
  logic [31:0] m_addr, m_store;

  mem_arbiter #(.NREQ(N), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .req_ren(ren), .req_wen(wen),
    .req_addr(req_addr), .req_store(req_store), .req_hit(req_hit),
    .req_load(req_load), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_store(mem_store), .mem_load(mem_load),
    .mem_wait(mem_wait), .grant_valid(grant_valid), .grant_id(grant_id),
    .err_timeout(err_timeout)
  );

  initial forever #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32]  = a_arr[i];
      req_store[i*32 +: 32] = s_arr[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_g = 0; m_ptr = 0; m_waits = 0; m_addr = '0; m_store = '0;
  endtask

  function automatic bit m_timeout();
    return m_busy && (m_waits >= TO);
  endfunction

  // Compare all outputs against the model at the falling edge.
  task automatic sample();
    bit to, pres;
    logic [N-1:0] e_hit;
    @(negedge CLK);
    to   = m_timeout();
    pres = m_busy && (ren[m_g] | wen[m_g]);
    e_hit = '0;
    if (m_busy && !to && pres && !mem_wait) e_hit[m_g] = 1'b1;
    chk("grant_valid", grant_valid, m_busy);
    chk("grant_id", grant_id, m_g);
    chk("mem_ren", mem_ren, m_busy && !to && ren[m_g] && !wen[m_g]);
    chk("mem_wen", mem_wen, m_busy && !to && wen[m_g]);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_store", mem_store, m_store);
    chk("req_hit", req_hit, e_hit);
    chk("err_timeout", err_timeout, to);
    if (e_hit != '0) chk("req_load", req_load, mem_load);
  endtask

  // Advance the model across the rising edge using the inputs present there.
  task automatic advance();
    bit to, pres;
    @(posedge CLK);
    to   = m_timeout();
    pres = m_busy && (ren[m_g] | wen[m_g]);
    if (m_busy) begin
      if (to || !pres || !mem_wait) begin
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % N;
      end else begin
        m_waits++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!m_busy && (ren[i] | wen[i])) begin
          m_busy = 1'b1; m_g = i; m_waits = 0; m_addr = a_arr[i]; m_store = s_arr[i];
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; ren = '0; wen = '0; model_reset();
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0]  ren, wen;
    logic        mw;
    logic [31:0] load;
    logic        e_valid, e_ren, e_wen;
    logic [3:0]  e_hit;
    logic [1:0]  e_gid;
    logic [31:0] e_addr, e_store;
  } vec_t;

  vec_t tbl[10];
  int   rr_ids[$];
  int   rr_cyc[$];
  int   nerr;

  initial begin
    nRST = 1'b0; ren = '0; wen = '0; mem_wait = 1'b0; mem_load = '0;
    a_arr[0] = 32'h100; a_arr[1] = 32'h200; a_arr[2] = 32'h300; a_arr[3] = 32'h400;
    s_arr[0] = 32'hAAAA0000; s_arr[1] = 32'h12345678; s_arr[2] = 32'h33330000; s_arr[3] = 32'h44440000;
    model_reset();
    @(posedge CLK); #1;
    chk("rst_valid", grant_valid, 1'b0);
    chk("rst_gid", grant_id, 2'd0);
    chk("rst_ren", mem_ren, 1'b0);
    chk("rst_wen", mem_wen, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_store", mem_store, 32'h0);
    chk("rst_hit", req_hit, 4'b0);
    chk("rst_err", err_timeout, 1'b0);
    nRST = 1'b1;

    // Read with three wait cycles, then a write-wins access from requester 1.
    tbl[0] = '{4'b0001, 4'b0000, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 32'h0,   32'h0};
    tbl[1] = '{4'b0001, 4'b0000, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 32'h100, 32'hAAAA0000};
    tbl[2] = tbl[1];
    tbl[3] = tbl[1];
    tbl[4] = '{4'b0001, 4'b0000, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 32'h100, 32'hAAAA0000};
    tbl[5] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 32'h0,   32'h0};
    tbl[6] = '{4'b0010, 4'b0010, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 32'h0,   32'h0};
    tbl[7] = '{4'b0010, 4'b0010, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 4'b0000, 2'd1, 32'h200, 32'h12345678};
    tbl[8] = '{4'b0010, 4'b0010, 1'b0, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 32'h200, 32'h12345678};
    tbl[9] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 32'h0,   32'h0};
    for (int r = 0; r < 10; r++) begin
      ren = tbl[r].ren; wen = tbl[r].wen; mem_wait = tbl[r].mw; mem_load = tbl[r].load;
      sample();
      chk($sformatf("tbl%0d_valid", r), grant_valid, tbl[r].e_valid);
      chk($sformatf("tbl%0d_ren", r), mem_ren, tbl[r].e_ren);
      chk($sformatf("tbl%0d_wen", r), mem_wen, tbl[r].e_wen);
      chk($sformatf("tbl%0d_hit", r), req_hit, tbl[r].e_hit);
      chk($sformatf("tbl%0d_gid", r), grant_id, tbl[r].e_gid);
      if (tbl[r].e_valid) begin
        chk($sformatf("tbl%0d_addr", r), mem_addr, tbl[r].e_addr);
        chk($sformatf("tbl%0d_store", r), mem_store, tbl[r].e_store);
      end
      if (tbl[r].e_hit != 4'b0) chk($sformatf("tbl%0d_load", r), req_load, tbl[r].load);
      advance();
    end

    // Four requesters holding reads: grants rotate 0,1,2,3,0, one hit per 2 cycles.
    do_reset();
    ren = 4'b1111; mem_wait = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mem_load = $urandom;
      sample();
      if (req_hit != '0) begin rr_ids.push_back(int'(grant_id)); rr_cyc.push_back(c); end
      advance();
    end
    ren = '0;
    chk("rr_count", rr_ids.size(), 5);
    for (int i = 0; i < rr_ids.size() && i < 5; i++) begin
      chk($sformatf("rr_id%0d", i), rr_ids[i], i % 4);
      chk($sformatf("rr_cyc%0d", i), rr_cyc[i], 2 * i + 1);
    end

    // Withdrawal while waiting: abort, then requester 1 is next.
    do_reset();
    ren = 4'b0011; mem_wait = 1'b1;
    sample(); advance();
    sample(); chk("ab_gid0", grant_id, 2'd0); chk("ab_ren0", mem_ren, 1'b1); advance();
    ren = 4'b0010;
    sample(); chk("ab_strobe", mem_ren, 1'b0); chk("ab_nohit", req_hit, 4'b0); advance();
    sample(); chk("ab_idle", grant_valid, 1'b0); advance();
    sample(); chk("ab_gid1", grant_id, 2'd1); chk("ab_valid", grant_valid, 1'b1); advance();
    mem_wait = 1'b0;
    sample(); chk("ab_hit1", req_hit, 4'b0010); advance();
    ren = '0;
    sample(); advance();

    // Watchdog: mem_wait stuck high on requester 2.
    do_reset();
    ren = 4'b0100; mem_wait = 1'b1; nerr = 0;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (err_timeout) nerr++;
      if (c >= 1 && c <= 4) chk($sformatf("to_wait%0d", c), mem_ren, 1'b1);
      if (c == 5) begin
        chk("to_err", err_timeout, 1'b1);
        chk("to_strobe", mem_ren, 1'b0);
        chk("to_nohit", req_hit, 4'b0);
      end
      advance();
    end
    ren = 4'b1100;
    sample(); if (err_timeout) nerr++; chk("to_idle", grant_valid, 1'b0); advance();
    chk("to_pulses", nerr, 1);
    sample(); chk("to_ptr", grant_id, 2'd3); chk("to_valid", grant_valid, 1'b1);

    // Asynchronous reset in the middle of that access.
    nRST = 1'b0; #1;
    chk("ar_valid", grant_valid, 1'b0);
    chk("ar_ren", mem_ren, 1'b0);
    chk("ar_hit", req_hit, 4'b0);
    chk("ar_gid", grant_id, 2'd0);
    chk("ar_addr", mem_addr, 32'h0);
    model_reset();
    ren = 4'b1001; mem_wait = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    sample(); chk("ar_idle", grant_valid, 1'b0); advance();
    sample(); chk("ar_first", grant_id, 2'd0); chk("ar_hit0", req_hit, 4'b0001); advance();
    ren = '0;
    sample(); advance();

    // Random traffic with periodic stuck-wait bursts.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) ren[i] = ~ren[i];
        if ($urandom_range(15) == 0) wen[i] = ~wen[i];
        if ($urandom_range(3) == 0) a_arr[i] = $urandom;
        s_arr[i] = $urandom;
      end
      mem_wait = ((c % 100) < 8) ? 1'b1 : ($urandom_range(9) < 4);
      mem_load = $urandom;
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
